// File: rtl/clk_div_pkg.sv
// Shared types and constants for the divider configuration controller.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DONE = 2'd2
  } div_cfg_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_INVALID = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam int unsigned DEF_DIV_WIDTH = 32;

endpackage

// File: rtl/dffer.sv
// Enabled register with asynchronous active-low reset to a parameterised value.
module dffer #(
  parameter int unsigned      Width  = 1,
  parameter logic [Width-1:0] RstVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_o <= RstVal;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/dffr.sv
// Plain register with asynchronous active-low reset to a parameterised value.
module dffr #(
  parameter int unsigned      Width  = 1,
  parameter logic [Width-1:0] RstVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_o <= RstVal;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/clk_int_div_cfg_ctrl.sv
// Validates ratio writes, hands them to the even divider over valid/ready, and commits them
// as current once the divider reports done. Keeps a one-deep pending slot for writes while busy.
module clk_int_div_cfg_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_WIDTH   = DEF_DIV_WIDTH,
  parameter int unsigned DEF_DIV     = 4,
  parameter bit          INIT_LOAD   = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 cfg_wr_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic                 err_clr_i,
  output logic                 cfg_busy_o,
  output logic [1:0]           err_o,
  output logic [DIV_WIDTH-1:0] cur_div_o,
  output logic [7:0]           upd_cnt_o,
  output logic [DIV_WIDTH-1:0] div_o,
  output logic                 div_valid_o,
  input  logic                 div_ready_i,
  input  logic                 div_done_i
);

  localparam int unsigned          CntW    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [DIV_WIDTH-1:0] DefDiv  = DIV_WIDTH'(DEF_DIV);
  localparam logic [CntW-1:0]      TmoLast = CntW'(TIMEOUT_CYC - 1);

  div_cfg_state_e       state_q, state_d;
  logic [1:0]           state_raw;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] cur_div_q;
  logic [7:0]           upd_cnt_q;
  logic [1:0]           err_q, err_d;
  logic                 pend_v_q, pend_v_d;
  logic [DIV_WIDTH-1:0] pend_div_q;
  logic [CntW-1:0]      tmo_q, tmo_d;
  logic                 init_q;

  logic                 wr_ok, wr_bad, idle_free, issue, commit, timeout, pend_load;
  logic [DIV_WIDTH-1:0] issue_div;

  assign state_q = div_cfg_state_e'(state_raw);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    err_d     = err_q;
    pend_v_d  = pend_v_q;
    issue     = 1'b0;
    issue_div = cfg_div_i;
    commit    = 1'b0;
    timeout   = 1'b0;

    wr_ok     = cfg_wr_i && (cfg_div_i != '0) && !cfg_div_i[0];
    wr_bad    = cfg_wr_i && !wr_ok;
    // Only a truly idle controller compares a write against cur_div; otherwise it is queued.
    idle_free = (state_q == IDLE) && !init_q && !pend_v_q;

    unique case (state_q)
      IDLE: begin
        if (init_q) begin
          issue     = 1'b1;
          issue_div = DefDiv;
        end else if (pend_v_q) begin
          issue     = 1'b1;
          issue_div = pend_div_q;
          pend_v_d  = 1'b0;
        end else if (wr_ok && (cfg_div_i != cur_div_q)) begin
          issue = 1'b1;
        end
      end
      REQ: begin
        if (tmo_q == TmoLast) begin
          timeout = 1'b1;
        end else if (div_ready_i) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // The divider has already switched, so a done on the last cycle still commits.
        if (div_done_i) begin
          commit  = 1'b1;
          state_d = IDLE;
          if (pend_v_q) begin
            issue     = 1'b1;
            issue_div = pend_div_q;
            pend_v_d  = 1'b0;
          end
        end else if (tmo_q == TmoLast) begin
          timeout = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d = IDLE;
    end
    if (issue) begin
      state_d = REQ;
      div_d   = issue_div;
    end

    pend_load = wr_ok && !idle_free;
    if (pend_load) begin
      pend_v_d = 1'b1;
    end

    if (issue) begin
      tmo_d = '0;
    end else if (state_q != IDLE) begin
      tmo_d = tmo_q + CntW'(1);
    end else begin
      tmo_d = tmo_q;
    end

    if (err_clr_i) begin
      err_d = ERR_NONE;
    end
    if (wr_bad) begin
      err_d = ERR_INVALID;
    end
    if (timeout) begin
      err_d = ERR_TIMEOUT;
    end
  end

  dffr #(.Width(2), .RstVal(2'(IDLE))) u_state (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (state_d),
    .q_o     (state_raw)
  );

  dffr #(.Width(DIV_WIDTH), .RstVal(DefDiv)) u_div (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (div_d),
    .q_o     (div_q)
  );

  dffer #(.Width(DIV_WIDTH), .RstVal(DefDiv)) u_cur_div (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (commit),
    .d_i     (div_q),
    .q_o     (cur_div_q)
  );

  dffer #(.Width(8), .RstVal(8'd0)) u_upd_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (commit),
    .d_i     (upd_cnt_q + 8'd1),
    .q_o     (upd_cnt_q)
  );

  dffr #(.Width(2), .RstVal(ERR_NONE)) u_err (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (err_d),
    .q_o     (err_q)
  );

  dffr #(.Width(1), .RstVal(1'b0)) u_pend_v (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (pend_v_d),
    .q_o     (pend_v_q)
  );

  dffer #(.Width(DIV_WIDTH), .RstVal('0)) u_pend_div (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (pend_load),
    .d_i     (cfg_div_i),
    .q_o     (pend_div_q)
  );

  dffr #(.Width(CntW), .RstVal('0)) u_tmo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (tmo_d),
    .q_o     (tmo_q)
  );

  // Set through reset, cleared on the first edge after release.
  dffr #(.Width(1), .RstVal(INIT_LOAD)) u_init (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (1'b0),
    .q_o     (init_q)
  );

  assign div_o       = div_q;
  assign div_valid_o = (state_q == REQ);
  assign cfg_busy_o  = (state_q != IDLE) || pend_v_q;
  assign err_o       = err_q;
  assign cur_div_o   = cur_div_q;
  assign upd_cnt_o   = upd_cnt_q;

endmodule

// File: tb/tb_clk_int_div_cfg_ctrl.sv
// Randomised and directed bench for clk_int_div_cfg_ctrl against a transaction-level model.
module tb_clk_int_div_cfg_ctrl;

  localparam int unsigned W   = 32;
  localparam int          DEF = 4;
  localparam int          TMO = 16;

  logic         clk_i       = 1'b0;
  logic         rst_n_i     = 1'b0;
  logic         cfg_wr_i    = 1'b0;
  logic [W-1:0] cfg_div_i   = '0;
  logic         err_clr_i   = 1'b0;
  logic         div_ready_i = 1'b0;
  logic         div_done_i  = 1'b0;
  logic         cfg_busy_o;
  logic [1:0]   err_o;
  logic [W-1:0] cur_div_o;
  logic [7:0]   upd_cnt_o;
  logic [W-1:0] div_o;
  logic         div_valid_o;

  always #5 clk_i = ~clk_i;

  clk_int_div_cfg_ctrl #(
    .DIV_WIDTH   (W),
    .DEF_DIV     (DEF),
    .INIT_LOAD   (1'b1),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .cfg_wr_i    (cfg_wr_i),
    .cfg_div_i   (cfg_div_i),
    .err_clr_i   (err_clr_i),
    .cfg_busy_o  (cfg_busy_o),
    .err_o       (err_o),
    .cur_div_o   (cur_div_o),
    .upd_cnt_o   (upd_cnt_o),
    .div_o       (div_o),
    .div_valid_o (div_valid_o),
    .div_ready_i (div_ready_i),
    .div_done_i  (div_done_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a request is either offered (m_req), accepted and awaiting done (m_wait), or absent.
  bit m_req    = 1'b0;
  bit m_wait   = 1'b0;
  bit m_pend_v = 1'b0;
  bit m_first  = 1'b1;
  int m_div    = DEF;
  int m_cur    = DEF;
  int m_cnt    = 0;
  int m_err    = 0;
  int m_age    = 0;
  int m_pend   = 0;

  task automatic model_reset();
    m_req = 1'b0; m_wait = 1'b0; m_pend_v = 1'b0; m_first = 1'b1;
    m_div = DEF; m_cur = DEF; m_cnt = 0; m_err = 0; m_age = 0; m_pend = 0;
  endtask

  task automatic model_step();
    bit ok, bad, idle, free, tmo;
    int start, wv;
    wv    = int'(cfg_div_i);
    ok    = cfg_wr_i && (wv != 0) && (wv % 2 == 0);
    bad   = cfg_wr_i && !ok;
    idle  = !m_req && !m_wait;
    free  = idle && !m_first && !m_pend_v;
    tmo   = 1'b0;
    start = -1;
    if (idle) begin
      if (m_first) start = DEF;
      else if (m_pend_v) begin start = m_pend; m_pend_v = 1'b0; end
      else if (ok && wv != m_cur) start = wv;
    end else if (m_req) begin
      if (m_age == TMO - 1) tmo = 1'b1;
      else if (div_ready_i) begin m_req = 1'b0; m_wait = 1'b1; end
    end else begin
      if (div_done_i) begin
        m_cur  = m_div;
        m_cnt  = (m_cnt + 1) % 256;
        m_wait = 1'b0;
        if (m_pend_v) begin start = m_pend; m_pend_v = 1'b0; end
      end else if (m_age == TMO - 1) begin
        tmo = 1'b1;
      end
    end
    if (ok && !free) begin m_pend_v = 1'b1; m_pend = wv; end
    if (!idle) m_age = m_age + 1;
    if (tmo) begin m_req = 1'b0; m_wait = 1'b0; end
    if (start >= 0) begin m_req = 1'b1; m_wait = 1'b0; m_div = start; m_age = 0; end
    if (err_clr_i) m_err = 0;
    if (bad) m_err = 1;
    if (tmo) m_err = 2;
    m_first = 1'b0;
  endtask

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) model_reset();
    else model_step();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("mdl_valid", 32'(div_valid_o), 32'(m_req));
    chk("mdl_busy", 32'(cfg_busy_o), 32'(m_req || m_wait || m_pend_v));
    chk("mdl_err", 32'(err_o), 32'(m_err));
    chk("mdl_cur", cur_div_o, 32'(m_cur));
    chk("mdl_cnt", 32'(upd_cnt_o), 32'(m_cnt));
    chk("mdl_div", div_o, 32'(m_div));
  endtask

  task automatic cyc();
    @(posedge clk_i);
    @(negedge clk_i);
    compare_model();
  endtask

  task automatic wr(input int v);
    cfg_wr_i  = 1'b1;
    cfg_div_i = W'(v);
  endtask

  initial begin
    // Reset state
    div_ready_i = 1'b1;
    div_done_i  = 1'b1;
    cyc();
    cyc();
    chk("rst_cur", cur_div_o, 32'd4);
    chk("rst_div", div_o, 32'd4);
    chk("rst_valid", 32'(div_valid_o), 32'd0);
    chk("rst_busy", 32'(cfg_busy_o), 32'd0);
    chk("rst_cnt", 32'(upd_cnt_o), 32'd0);

    // Automatic initial load of the default ratio
    rst_n_i = 1'b1;
    cyc();
    chk("init_valid", 32'(div_valid_o), 32'd1);
    chk("init_div", div_o, 32'd4);
    cyc();
    chk("init_valid_drop", 32'(div_valid_o), 32'd0);
    cyc();
    chk("init_cur", cur_div_o, 32'd4);
    chk("init_cnt", 32'(upd_cnt_o), 32'd1);
    chk("init_err", 32'(err_o), 32'd0);

    // Single update to 8
    wr(8);
    cyc();
    cfg_wr_i = 1'b0;
    chk("w8_valid", 32'(div_valid_o), 32'd1);
    cyc();
    cyc();
    chk("w8_cur", cur_div_o, 32'd8);
    chk("w8_cnt", 32'(upd_cnt_o), 32'd2);

    // Invalid ratios are dropped with a sticky error
    wr(7);
    cyc();
    chk("odd_err", 32'(err_o), 32'd1);
    wr(0);
    cyc();
    cfg_wr_i = 1'b0;
    chk("zero_err", 32'(err_o), 32'd1);
    chk("zero_valid", 32'(div_valid_o), 32'd0);
    chk("zero_cur", cur_div_o, 32'd8);
    err_clr_i = 1'b1;
    cyc();
    err_clr_i = 1'b0;
    chk("clr_err", 32'(err_o), 32'd0);

    // Writes during WAIT_DONE: latest wins
    div_done_i = 1'b0;
    wr(10);
    cyc();
    cfg_wr_i = 1'b0;
    cyc();
    wr(12);
    cyc();
    wr(16);
    cyc();
    cfg_wr_i   = 1'b0;
    div_done_i = 1'b1;
    cyc();
    chk("pend_cur10", cur_div_o, 32'd10);
    chk("pend_div16", div_o, 32'd16);
    chk("pend_valid", 32'(div_valid_o), 32'd1);
    cyc();
    cyc();
    chk("pend_cur16", cur_div_o, 32'd16);
    chk("pend_cnt", 32'(upd_cnt_o), 32'd4);
    chk("pend_busy", 32'(cfg_busy_o), 32'd0);

    // Writing the current ratio while idle is a no-op
    wr(16);
    cyc();
    cfg_wr_i = 1'b0;
    chk("noop_valid", 32'(div_valid_o), 32'd0);
    chk("noop_busy", 32'(cfg_busy_o), 32'd0);

    // Timeout: done never arrives
    div_done_i = 1'b0;
    wr(20);
    cyc();
    cfg_wr_i = 1'b0;
    for (int i = 0; i < 15; i++) cyc();
    chk("tmo_err_before", 32'(err_o), 32'd0);
    chk("tmo_busy_before", 32'(cfg_busy_o), 32'd1);
    cyc();
    chk("tmo_err", 32'(err_o), 32'd2);
    chk("tmo_busy", 32'(cfg_busy_o), 32'd0);
    chk("tmo_cur", cur_div_o, 32'd16);
    err_clr_i = 1'b1;
    cyc();
    err_clr_i = 1'b0;

    // Asynchronous reset while waiting for done
    wr(6);
    cyc();
    cfg_wr_i = 1'b0;
    cyc();
    #2 rst_n_i = 1'b0;
    #1;
    chk("arst_cur", cur_div_o, 32'd4);
    chk("arst_div", div_o, 32'd4);
    chk("arst_cnt", 32'(upd_cnt_o), 32'd0);
    chk("arst_busy", 32'(cfg_busy_o), 32'd0);
    chk("arst_valid", 32'(div_valid_o), 32'd0);
    cyc();
    rst_n_i    = 1'b1;
    div_done_i = 1'b1;
    cyc();
    cyc();
    cyc();

    // 255 more updates after the initial load wrap the counter to 0
    for (int i = 0; i < 255; i++) begin
      wr((i % 2 == 0) ? 8 : 6);
      cyc();
      cfg_wr_i = 1'b0;
      cyc();
      cyc();
    end
    chk("wrap_cnt", 32'(upd_cnt_o), 32'd0);
    chk("wrap_cur", cur_div_o, 32'd8);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      cfg_wr_i    = ($urandom_range(0, 3) == 0);
      cfg_div_i   = ($urandom_range(0, 7) == 0) ? W'(m_cur) : W'($urandom_range(0, 24));
      err_clr_i   = ($urandom_range(0, 15) == 0);
      div_ready_i = ($urandom_range(0, 2) != 0);
      div_done_i  = ($urandom_range(0, 3) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
